dqn_step_sequencer: RTL and testbench

//  Sequences one DQN training step at a time for the 3x3 grid agent: drives the

---
 rtl/dqn_step_sequencer.sv | 170 +++++++++++++++++
 tb/tb_dqn_step_sequencer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/dqn_step_sequencer.sv
// DQN training-step sequencer: walks each step through its phases, handshakes with the Q-network and counts episodes.
// Optional wait-phase watchdog enabled by defining DQN_SEQ_WATCHDOG_EN.
module dqn_step_sequencer #(
    parameter int MAX_STEP     = 14,
    parameter int GOAL_STATE   = 9,
    parameter int NUM_EPISODES = 16,
    parameter int EPW          = 8,
    parameter int TIMEOUT      = 255
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [3:0]     st,
    input  logic           net_done,
    input  logic           train_done,
    output logic [3:0]     controller,
    output logic [3:0]     step,
    output logic           net_start,
    output logic           train_start,
    output logic [EPW-1:0] episode,
    output logic           episode_done,
    output logic           all_done,
    output logic           err
);

    // state        | meaning
    // S_IDLE       | waiting for start
    // S_COMMIT     | latch step context
    // S_FWD_REQ    | pulse net_start
    // S_FWD_WAIT   | wait for net_done
    // S_ACT_SEL    | action selection
    // S_REWARD     | reward evaluation
    // S_TRANSITION | grid state transition
    // S_TRAIN_WAIT | pulse train_start on entry, wait for train_done
    // S_DONE       | all episodes complete
    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_COMMIT     = 4'd1,
        S_FWD_REQ    = 4'd2,
        S_FWD_WAIT   = 4'd3,
        S_ACT_SEL    = 4'd4,
        S_REWARD     = 4'd5,
        S_TRANSITION = 4'd6,
        S_TRAIN_WAIT = 4'd7,
        S_DONE       = 4'd8
    } state_t;

    state_t         state, state_next;
    logic [3:0]     step_next;
    logic [EPW-1:0] episode_next;
    logic [EPW-1:0] episode_inc;
    logic           ep_done_next;
    logic           train_entry;
    logic           ep_done_q;
    logic           ep_end;
    logic           timeout;

    assign episode_inc = episode + 1'b1;
    assign ep_end      = (step == 4'(MAX_STEP)) || (st == 4'(GOAL_STATE));

`ifdef DQN_SEQ_WATCHDOG_EN
    localparam int WDW = $clog2(TIMEOUT + 1);

    logic [WDW-1:0] wd_cnt;
    logic           err_q;
    logic           in_wait;
    logic           wait_entry;

    assign in_wait    = (state == S_FWD_WAIT) || (state == S_TRAIN_WAIT);
    assign wait_entry = ((state_next == S_FWD_WAIT) || (state_next == S_TRAIN_WAIT))
                        && (state_next != state);
    assign timeout    = in_wait && (wd_cnt == '0);
    assign err        = err_q;

    // Down-counter loaded on wait entry; terminal count means TIMEOUT cycles elapsed without done
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            if (wait_entry)
                wd_cnt <= WDW'(TIMEOUT - 1);
            else if (in_wait && wd_cnt != '0)
                wd_cnt <= wd_cnt - 1'b1;
            if (timeout && state_next == S_IDLE)
                err_q <= 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    always_comb begin
        state_next   = state;
        step_next    = step;
        episode_next = episode;
        ep_done_next = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_next   = S_COMMIT;
                    step_next    = 4'd1;
                    episode_next = '0;
                end
            end
            S_COMMIT:     state_next = S_FWD_REQ;
            S_FWD_REQ:    state_next = S_FWD_WAIT;
            S_FWD_WAIT: begin
                if (net_done) begin
                    state_next = S_ACT_SEL;
                end else if (timeout) begin
                    state_next = S_IDLE;
                    step_next  = 4'd0;
                end
            end
            S_ACT_SEL:    state_next = S_REWARD;
            S_REWARD:     state_next = S_TRANSITION;
            S_TRANSITION: state_next = S_TRAIN_WAIT;
            S_TRAIN_WAIT: begin
                if (train_done) begin
                    if (ep_end) begin
                        ep_done_next = 1'b1;
                        episode_next = episode_inc;
                        if (episode_inc == EPW'(NUM_EPISODES)) begin
                            state_next = S_DONE;
                            step_next  = 4'd0;
                        end else begin
                            state_next = S_COMMIT;
                            step_next  = 4'd1;
                        end
                    end else begin
                        state_next = S_COMMIT;
                        step_next  = step + 4'd1;
                    end
                end else if (timeout) begin
                    state_next = S_IDLE;
                    step_next  = 4'd0;
                end
            end
            default: begin
                state_next = S_IDLE;
                step_next  = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            step        <= 4'd0;
            episode     <= '0;
            train_entry <= 1'b0;
            ep_done_q   <= 1'b0;
        end else begin
            state       <= state_next;
            step        <= step_next;
            episode     <= episode_next;
            train_entry <= (state_next == S_TRAIN_WAIT) && (state != S_TRAIN_WAIT);
            ep_done_q   <= ep_done_next;
        end
    end

    assign controller   = state;
    assign net_start    = (state == S_FWD_REQ);
    assign train_start  = train_entry;
    assign episode_done = ep_done_q;
    assign all_done     = (state == S_DONE);

endmodule

// File: tb/tb_dqn_step_sequencer.sv
// Self-checking bench for dqn_step_sequencer: randomized handshake delays and grid states against a per-step phase model.
module tb_dqn_step_sequencer;
    localparam int MAX_STEP = 14;
    localparam int GOAL     = 9;
    localparam int NE       = 3;
    localparam int TO       = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [3:0] st = 4'd0;
    logic       net_done = 1'b0;
    logic       train_done = 1'b0;
    logic [3:0] controller, step;
    logic       net_start, train_start, episode_done, all_done, err;
    logic [7:0] episode;

    int errors = 0;
    int checks = 0;
    int m_step;
    int m_ep;
    bit m_done;

    dqn_step_sequencer #(.MAX_STEP(MAX_STEP), .GOAL_STATE(GOAL), .NUM_EPISODES(NE),
                         .EPW(8), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .st(st), .net_done(net_done),
        .train_done(train_done), .controller(controller), .step(step),
        .net_start(net_start), .train_start(train_start), .episode(episode),
        .episode_done(episode_done), .all_done(all_done), .err(err));

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One training step from COMMIT to the cycle after TRAIN_WAIT, checked against the phase model
    task automatic run_step(input int nd_delay, input int td_delay, input logic [3:0] st_val);
        bit ep_end;
        checks++; if (controller !== 4'd1) begin errors++; $display("FAIL commit_ctrl: got %0d expected 1", controller); end
        checks++; if (step !== 4'(m_step)) begin errors++; $display("FAIL commit_step: got %0d expected %0d", step, m_step); end
        checks++; if (episode !== 8'(m_ep)) begin errors++; $display("FAIL commit_episode: got %0d expected %0d", episode, m_ep); end
        tick;
        checks++; if (controller !== 4'd2 || net_start !== 1'b1) begin errors++; $display("FAIL fwd_req: ctrl=%0d net_start=%0b expected 2/1", controller, net_start); end
        tick;
        checks++; if (controller !== 4'd3 || net_start !== 1'b0) begin errors++; $display("FAIL fwd_wait: ctrl=%0d net_start=%0b expected 3/0", controller, net_start); end
        for (int i = 0; i < nd_delay; i++) begin
            tick;
            checks++; if (controller !== 4'd3) begin errors++; $display("FAIL fwd_hold: got %0d expected 3", controller); end
        end
        net_done = 1'b1;
        tick;
        net_done = 1'b0;
        for (int p = 4; p <= 6; p++) begin
            checks++; if (controller !== 4'(p)) begin errors++; $display("FAIL phase_%0d: got %0d expected %0d", p, controller, p); end
            net_done = 1'($urandom_range(0, 1));
            start    = 1'($urandom_range(0, 1));
            tick;
            net_done = 1'b0;
            start    = 1'b0;
        end
        checks++; if (controller !== 4'd7 || train_start !== 1'b1) begin errors++; $display("FAIL train_entry: ctrl=%0d train_start=%0b expected 7/1", controller, train_start); end
        checks++; if (step !== 4'(m_step)) begin errors++; $display("FAIL train_step: got %0d expected %0d", step, m_step); end
        st = st_val;
        for (int i = 0; i < td_delay; i++) begin
            tick;
            checks++; if (controller !== 4'd7 || train_start !== 1'b0) begin errors++; $display("FAIL train_hold: ctrl=%0d train_start=%0b expected 7/0", controller, train_start); end
        end
        train_done = 1'b1;
        tick;
        train_done = 1'b0;
        ep_end = (m_step == MAX_STEP) || (st_val == 4'(GOAL));
        if (ep_end) begin
            m_ep++;
            m_step = 1;
            if (m_ep == NE) begin
                m_done = 1'b1;
                m_step = 0;
            end
        end else begin
            m_step++;
        end
        checks++; if (episode_done !== ep_end) begin errors++; $display("FAIL episode_done: got %0b expected %0b", episode_done, ep_end); end
        checks++; if (episode !== 8'(m_ep)) begin errors++; $display("FAIL episode_count: got %0d expected %0d", episode, m_ep); end
        checks++; if (step !== 4'(m_step)) begin errors++; $display("FAIL next_step: got %0d expected %0d", step, m_step); end
        checks++; if (controller !== (m_done ? 4'd8 : 4'd1)) begin errors++; $display("FAIL next_ctrl: got %0d expected %0d", controller, m_done ? 8 : 1); end
        checks++; if (all_done !== m_done) begin errors++; $display("FAIL all_done: got %0b expected %0b", all_done, m_done); end
    endtask

    task automatic do_start;
        start = 1'b1;
        tick;
        start = 1'b0;
        m_step = 1;
        m_ep   = 0;
        m_done = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
        checks++; if (controller !== 4'd0 || step !== 4'd0 || episode !== 8'd0) begin errors++; $display("FAIL reset_state: ctrl=%0d step=%0d ep=%0d expected 0/0/0", controller, step, episode); end
        checks++; if ({net_start, train_start, episode_done, all_done, err} !== 5'b0) begin errors++; $display("FAIL reset_strobes: got %b expected 00000", {net_start, train_start, episode_done, all_done, err}); end
        tick;
        checks++; if (controller !== 4'd0) begin errors++; $display("FAIL idle_hold: got %0d expected 0", controller); end
    endtask

    // Full-length episode: st never reaches goal, one long forward wait
    task automatic test_full_episode;
        do_start;
        for (int s = 1; s <= MAX_STEP; s++)
            run_step((s == 5) ? 50 : $urandom_range(0, 3), $urandom_range(0, 3), 4'($urandom_range(0, 8)));
        checks++; if (m_ep !== 1) begin errors++; $display("FAIL full_episode_len: got %0d expected 1", m_ep); end
    endtask

    task automatic test_goal_early;
        for (int s = 1; s <= 3; s++)
            run_step(0, (s == 3) ? 0 : 1, (s == 3) ? 4'(GOAL) : 4'($urandom_range(0, 8)));
        checks++; if (m_ep !== 2 || m_step !== 1) begin errors++; $display("FAIL goal_early: ep=%0d step=%0d expected 2/1", m_ep, m_step); end
    endtask

    task automatic test_done_and_restart;
        int guard = 0;
        while (!m_done && guard < 40) begin
            run_step($urandom_range(0, 2), $urandom_range(0, 2),
                     ($urandom_range(0, 7) == 0) ? 4'(GOAL) : 4'($urandom_range(0, 8)));
            guard++;
        end
        checks++; if (!m_done) begin errors++; $display("FAIL done_reached: got 0 expected 1"); end
        for (int i = 0; i < 3; i++) begin
            tick;
            checks++; if (controller !== 4'd8 || all_done !== 1'b1 || step !== 4'd0) begin errors++; $display("FAIL done_hold: ctrl=%0d all_done=%0b step=%0d expected 8/1/0", controller, all_done, step); end
        end
        do_start;
        checks++; if (controller !== 4'd1 || step !== 4'd1 || all_done !== 1'b0 || episode !== 8'd0) begin errors++; $display("FAIL restart: ctrl=%0d step=%0d all_done=%0b ep=%0d expected 1/1/0/0", controller, step, all_done, episode); end
    endtask

    task automatic test_reset_mid_run;
        for (int s = 1; s <= 6; s++)
            run_step($urandom_range(0, 2), $urandom_range(0, 2), 4'($urandom_range(0, 8)));
        tick;
        tick;
        checks++; if (controller !== 4'd3 || step !== 4'd7) begin errors++; $display("FAIL pre_abort: ctrl=%0d step=%0d expected 3/7", controller, step); end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        checks++; if (controller !== 4'd0 || step !== 4'd0 || episode !== 8'd0) begin errors++; $display("FAIL abort: ctrl=%0d step=%0d ep=%0d expected 0/0/0", controller, step, episode); end
        checks++; if ({net_start, train_start, episode_done, all_done} !== 4'b0) begin errors++; $display("FAIL abort_strobes: got %b expected 0000", {net_start, train_start, episode_done, all_done}); end
    endtask

`ifdef DQN_SEQ_WATCHDOG_EN
    task automatic test_watchdog;
        int n = 0;
        do_start;
        tick;
        tick;
        while (controller == 4'd3 && n < 3 * TO) begin
            tick;
            n++;
        end
        checks++; if (n !== TO) begin errors++; $display("FAIL wd_cycles: got %0d expected %0d", n, TO); end
        checks++; if (err !== 1'b1 || controller !== 4'd0 || step !== 4'd0) begin errors++; $display("FAIL wd_abort: err=%0b ctrl=%0d step=%0d expected 1/0/0", err, controller, step); end
        do_start;
        checks++; if (controller !== 4'd1 || err !== 1'b1) begin errors++; $display("FAIL wd_restart: ctrl=%0d err=%0b expected 1/1", controller, err); end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL wd_clear: got %0b expected 0", err); end
    endtask
`endif

    initial begin
        test_reset;
        test_full_episode;
        test_goal_early;
        test_done_and_restart;
        test_reset_mid_run;
`ifdef DQN_SEQ_WATCHDOG_EN
        test_watchdog;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
